rle_blob_tracker: RTL and testbench

- Sits directly downstream of the per-line RLE encoder in the rover vision pipeline.
- Consumes one dominant white run per line (start column and length, sampled on the encoder's line-end pulse).
- Links vertically overlapping runs on consecutive lines into blobs and keeps the largest blob of the frame.
- At frame end, publishes that blob's bounding box, area and length-weighted horizontal centroid for the steering/Nios logic.

---
 rtl/rle_blob_tracker.sv | 217 +++++++++++++++++++++
 tb/tb_rle_blob_tracker.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/rle_blob_tracker.sv
// Links the dominant white run of each line into vertically connected blobs and,
// at frame end, reports the largest blob's bounding box, area and centroid.
module rle_blob_tracker #(
  parameter int IMAGE_W   = 640,
  parameter int IMAGE_H   = 480,
  parameter int MIN_LINES = 4,
  parameter int DIV_W     = 30
) (
  input  logic        CLK,
  input  logic        reset_n,
  input  logic        line_valid,
  input  logic [10:0] run_start,
  input  logic [10:0] run_len,
  input  logic        frame_end,
  output logic        busy,
  output logic        blob_valid,
  output logic        blob_found,
  output logic [10:0] blob_x_min,
  output logic [10:0] blob_x_max,
  output logic [9:0]  blob_y_min,
  output logic [9:0]  blob_y_max,
  output logic [18:0] blob_area,
  output logic [10:0] blob_cx,
  output logic        lines_dropped
);

  localparam int CNT_W = $clog2(DIV_W);

  typedef enum logic [1:0] {ACCUM, CLOSE, DIVIDE, DONE} state_t;

  state_t state, state_next;

  logic [9:0]       y;
  logic [10:0]      prev_start, prev_end;
  logic [10:0]      act_x_min, act_x_max;
  logic [9:0]       act_y_min, act_y_max;
  logic [9:0]       act_lines;
  logic [18:0]      act_area;
  logic [DIV_W-1:0] act_moment;
  logic [10:0]      best_x_min, best_x_max;
  logic [9:0]       best_y_min, best_y_max;
  logic [18:0]      best_area;
  logic [DIV_W-1:0] best_moment;

  logic [DIV_W-1:0] div_num;
  logic [DIV_W-1:0] div_rem;
  logic [DIV_W:0]   div_den;
  logic             div_zero;
  logic [CNT_W-1:0] div_cnt;

  logic [11:0]      run_sum;
  logic [10:0]      run_end;
  logic [12:0]      run_weight;
  logic [DIV_W-1:0] run_moment;
  logic             accept, overlap, close_now, replace;
  logic [18:0]      sel_area;
  logic [DIV_W-1:0] sel_moment;
  logic [DIV_W:0]   rem_shift;
  logic             q_bit;

  assign busy = (state != ACCUM);

  // Run geometry: end column clipped to the image, moment term len*(2*start+len-1).
  always_comb begin
    run_sum    = {1'b0, run_start} + {1'b0, run_len};
    run_end    = (run_sum > 12'(IMAGE_W)) ? 11'(IMAGE_W - 1) : 11'(run_sum - 12'd1);
    run_weight = {1'b0, run_start, 1'b0} + {2'b00, run_len} - 13'd1;
    run_moment = DIV_W'(run_len) * DIV_W'(run_weight);
  end

  always_comb begin
    accept    = (state == ACCUM) && line_valid;
    overlap   = (act_lines != 10'd0) && (y != 10'd0) && (act_y_max == y - 10'd1) &&
                (run_start <= prev_end) && (run_end >= prev_start);
    close_now = (accept && ((run_len == 11'd0) || !overlap)) || (state == CLOSE);
    replace   = (act_lines >= 10'(MIN_LINES)) && (act_area > best_area);
    sel_area   = replace ? act_area : best_area;
    sel_moment = replace ? act_moment : best_moment;
    rem_shift  = {div_rem, div_num[DIV_W-1]};
    q_bit      = !div_zero && (rem_shift >= div_den);
  end

  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (frame_end) state_next = CLOSE;
      CLOSE:   state_next = DIVIDE;
      DIVIDE:  if (div_cnt == CNT_W'(DIV_W - 1)) state_next = DONE;
      DONE:    state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!reset_n) state <= ACCUM;
    else          state <= state_next;
  end

  // Active blob tracking; CLOSE rewinds the line counter for the next frame.
  always_ff @(posedge CLK) begin
    if (!reset_n || state == CLOSE) begin
      y          <= '0;
      prev_start <= '0;
      prev_end   <= '0;
      act_x_min  <= '0;
      act_x_max  <= '0;
      act_y_min  <= '0;
      act_y_max  <= '0;
      act_lines  <= '0;
      act_area   <= '0;
      act_moment <= '0;
    end else if (accept) begin
      y          <= (y == 10'(IMAGE_H - 1)) ? y : y + 10'd1;
      prev_start <= run_start;
      prev_end   <= run_end;
      if (run_len == 11'd0) begin
        act_lines  <= '0;
        act_area   <= '0;
        act_moment <= '0;
      end else if (overlap) begin
        act_x_min  <= (run_start < act_x_min) ? run_start : act_x_min;
        act_x_max  <= (run_end > act_x_max) ? run_end : act_x_max;
        act_y_max  <= y;
        act_lines  <= act_lines + 10'd1;
        act_area   <= act_area + {8'd0, run_len};
        act_moment <= act_moment + run_moment;
      end else begin
        act_x_min  <= run_start;
        act_x_max  <= run_end;
        act_y_min  <= y;
        act_y_max  <= y;
        act_lines  <= 10'd1;
        act_area   <= {8'd0, run_len};
        act_moment <= run_moment;
      end
    end
  end

  // Strictly-greater area comparison keeps the earlier blob on ties.
  always_ff @(posedge CLK) begin
    if (!reset_n || state == DONE) begin
      best_x_min  <= '0;
      best_x_max  <= '0;
      best_y_min  <= '0;
      best_y_max  <= '0;
      best_area   <= '0;
      best_moment <= '0;
    end else if (close_now && replace) begin
      best_x_min  <= act_x_min;
      best_x_max  <= act_x_max;
      best_y_min  <= act_y_min;
      best_y_max  <= act_y_max;
      best_area   <= act_area;
      best_moment <= act_moment;
    end
  end

  // Restoring divider; div_num doubles as the quotient shift register.
  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      div_num  <= '0;
      div_rem  <= '0;
      div_den  <= '0;
      div_zero <= 1'b0;
      div_cnt  <= '0;
    end else if (state == CLOSE) begin
      div_num  <= sel_moment;
      div_rem  <= '0;
      div_den  <= (DIV_W + 1)'({sel_area, 1'b0});
      div_zero <= (sel_area == 19'd0);
      div_cnt  <= '0;
    end else if (state == DIVIDE) begin
      div_rem  <= q_bit ? DIV_W'(rem_shift - div_den) : DIV_W'(rem_shift);
      div_num  <= {div_num[DIV_W-2:0], q_bit};
      div_cnt  <= div_cnt + CNT_W'(1);
    end
  end

  // A line arriving in the DONE cycle is itself dropped, so it re-arms the flag.
  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      blob_valid    <= 1'b0;
      blob_found    <= 1'b0;
      blob_x_min    <= '0;
      blob_x_max    <= '0;
      blob_y_min    <= '0;
      blob_y_max    <= '0;
      blob_area     <= '0;
      blob_cx       <= '0;
      lines_dropped <= 1'b0;
    end else begin
      blob_valid <= (state == DONE);
      if (state == DONE) begin
        lines_dropped <= line_valid;
        blob_found    <= (best_area != 19'd0);
        if (best_area != 19'd0) begin
          blob_x_min <= best_x_min;
          blob_x_max <= best_x_max;
          blob_y_min <= best_y_min;
          blob_y_max <= best_y_max;
          blob_area  <= best_area;
          blob_cx    <= 11'(div_num);
        end else begin
          blob_x_min <= '0;
          blob_x_max <= '0;
          blob_y_min <= '0;
          blob_y_max <= '0;
          blob_area  <= '0;
          blob_cx    <= '0;
        end
      end else if (busy && line_valid) begin
        lines_dropped <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rle_blob_tracker.sv
// Scoreboard bench for rle_blob_tracker: frames push expected results, a
// monitor pops and compares them on every blob_valid pulse.
module tb_rle_blob_tracker;

  logic        CLK = 1'b0;
  logic        reset_n;
  logic        line_valid;
  logic [10:0] run_start;
  logic [10:0] run_len;
  logic        frame_end;
  logic        busy;
  logic        blob_valid;
  logic        blob_found;
  logic [10:0] blob_x_min, blob_x_max;
  logic [9:0]  blob_y_min, blob_y_max;
  logic [18:0] blob_area;
  logic [10:0] blob_cx;
  logic        lines_dropped;

  typedef struct {
    string  name;
    bit     found;
    int     x_min, x_max, y_min, y_max, area, cx;
    longint cyc;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   cur;
  int     checks = 0;
  int     errors = 0;
  longint cycle  = 0;

  rle_blob_tracker dut (
    .CLK           (CLK),
    .reset_n       (reset_n),
    .line_valid    (line_valid),
    .run_start     (run_start),
    .run_len       (run_len),
    .frame_end     (frame_end),
    .busy          (busy),
    .blob_valid    (blob_valid),
    .blob_found    (blob_found),
    .blob_x_min    (blob_x_min),
    .blob_x_max    (blob_x_max),
    .blob_y_min    (blob_y_min),
    .blob_y_max    (blob_y_max),
    .blob_area     (blob_area),
    .blob_cx       (blob_cx),
    .lines_dropped (lines_dropped)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cycle <= cycle + 1;

  task automatic check_output(input string nm, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", nm, actual, expected);
    end
  endtask

  // One-cycle line pulse, driven on the falling edge.
  task automatic apply_stimulus(input int s, input int l);
    @(negedge CLK);
    line_valid = 1'b1;
    run_start  = 11'(s);
    run_len    = 11'(l);
    @(negedge CLK);
    line_valid = 1'b0;
    run_start  = '0;
    run_len    = '0;
  endtask

  task automatic send_lines(input int n, input int s, input int l);
    for (int i = 0; i < n; i++) apply_stimulus(s, l);
  endtask

  task automatic end_frame(input string nm, input bit push, input bit found,
                           input int xmn, input int xmx, input int ymn, input int ymx,
                           input int ar, input int cx,
                           input bit with_line, input int s, input int l);
    exp_t e;
    @(negedge CLK);
    frame_end = 1'b1;
    if (with_line) begin
      line_valid = 1'b1;
      run_start  = 11'(s);
      run_len    = 11'(l);
    end
    e.name = nm; e.found = found;
    e.x_min = xmn; e.x_max = xmx; e.y_min = ymn; e.y_max = ymx;
    e.area = ar; e.cx = cx;
    e.cyc = cycle + 33;
    if (push) exp_q.push_back(e);
    @(negedge CLK);
    frame_end  = 1'b0;
    line_valid = 1'b0;
    run_start  = '0;
    run_len    = '0;
  endtask

  always @(negedge CLK) begin
    if (reset_n === 1'b1 && blob_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_blob_valid: got blob_valid=1 expected no result");
      end else begin
        cur = exp_q.pop_front();
        check_output({cur.name, ".latency"}, cycle, cur.cyc);
        check_output({cur.name, ".found"}, blob_found, cur.found);
        check_output({cur.name, ".x_min"}, blob_x_min, cur.x_min);
        check_output({cur.name, ".x_max"}, blob_x_max, cur.x_max);
        check_output({cur.name, ".y_min"}, blob_y_min, cur.y_min);
        check_output({cur.name, ".y_max"}, blob_y_max, cur.y_max);
        check_output({cur.name, ".area"}, blob_area, cur.area);
        check_output({cur.name, ".cx"}, blob_cx, cur.cx);
        check_output({cur.name, ".dropped"}, lines_dropped, 0);
      end
    end
  end

  initial begin
    reset_n = 1'b0; line_valid = 1'b0; frame_end = 1'b0;
    run_start = '0; run_len = '0;
    repeat (3) @(negedge CLK);
    check_output("reset.blob_valid", blob_valid, 0);
    check_output("reset.busy", busy, 0);
    check_output("reset.found", blob_found, 0);
    check_output("reset.area", blob_area, 0);
    check_output("reset.dropped", lines_dropped, 0);
    reset_n = 1'b1;

    $display("[TB] basic blob");
    send_lines(10, 100, 50);
    end_frame("basic", 1, 1, 100, 149, 0, 9, 500, 124, 0, 0, 0);
    repeat (2) @(negedge CLK);
    check_output("basic.busy_during", busy, 1);
    repeat (40) @(negedge CLK);
    check_output("basic.busy_after", busy, 0);

    $display("[TB] empty frame");
    send_lines(20, 0, 0);
    end_frame("empty", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (40) @(negedge CLK);

    $display("[TB] largest wins");
    send_lines(5, 10, 20);
    send_lines(5, 0, 0);
    send_lines(6, 300, 30);
    end_frame("largest", 1, 1, 300, 329, 10, 15, 180, 314, 0, 0, 0);
    repeat (40) @(negedge CLK);

    $display("[TB] split on non-overlap, tie keeps earlier");
    send_lines(5, 0, 10);
    send_lines(5, 200, 10);
    end_frame("split", 1, 1, 0, 9, 0, 4, 50, 4, 0, 0, 0);
    repeat (40) @(negedge CLK);

    $display("[TB] min lines");
    send_lines(3, 0, 600);
    end_frame("min3", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (40) @(negedge CLK);
    send_lines(4, 0, 600);
    end_frame("min4", 1, 1, 0, 599, 0, 3, 2400, 299, 0, 0, 0);
    repeat (40) @(negedge CLK);

    $display("[TB] line coincident with frame_end");
    send_lines(3, 50, 20);
    end_frame("coincident", 1, 1, 50, 69, 0, 3, 80, 59, 1, 50, 20);
    repeat (40) @(negedge CLK);

    $display("[TB] right edge clipping");
    send_lines(4, 630, 20);
    end_frame("clip", 1, 1, 630, 639, 0, 3, 80, 639, 0, 0, 0);
    repeat (40) @(negedge CLK);

    $display("[TB] line during divide");
    send_lines(10, 100, 50);
    end_frame("drop", 1, 1, 100, 149, 0, 9, 500, 124, 0, 0, 0);
    repeat (5) @(negedge CLK);
    apply_stimulus(0, 600);
    check_output("drop.flag", lines_dropped, 1);
    check_output("drop.busy", busy, 1);
    repeat (40) @(negedge CLK);

    $display("[TB] reset during divide");
    send_lines(10, 100, 50);
    end_frame("reset_mid", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (10) @(negedge CLK);
    reset_n = 1'b0;
    @(negedge CLK);
    reset_n = 1'b1;
    check_output("reset_mid.busy", busy, 0);
    check_output("reset_mid.found", blob_found, 0);
    check_output("reset_mid.x_max", blob_x_max, 0);
    check_output("reset_mid.area", blob_area, 0);
    check_output("reset_mid.cx", blob_cx, 0);
    repeat (40) @(negedge CLK);

    $display("[TB] recovery after reset");
    send_lines(4, 0, 600);
    end_frame("recover", 1, 1, 0, 599, 0, 3, 2400, 299, 0, 0, 0);
    repeat (40) @(negedge CLK);

    check_output("pending_results", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
